// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Imported by the fetch queue and the fetch top level.
package fetch_pkg;

  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic pc_misaligned(
    input logic [ILEN-1:0] pc
  );
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} entries between fetch and decode.
// Flush empties it in one cycle; push and pop may coincide even when full.
import fetch_pkg::*;

module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  count_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] wr_ptr_d;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_ptr_d;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees the head slot, so a full queue can still take a push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: owns the PC, reads instruction memory and fills the queue.
// Redirects flush and restart fetch; bad PCs halt fetch until redirected.
import fetch_pkg::*;

module instruction_fetch #(
  parameter logic [ILEN-1:0] RESET_PC   = DEF_RESET_PC,
  parameter int              DEPTH      = 2,
  parameter int              IMEM_WORDS = 1024
) (
  input  logic            clk,
  input  logic            rst,
  output logic [ILEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [ILEN-1:0] out_pc,
  input  logic            redirect_valid,
  input  logic [ILEN-1:0] redirect_pc,
  output logic            fault
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [ILEN-1:0] LIMIT = IMEM_WORDS;

  logic [ILEN-1:0] pc_q;
  logic [ILEN-1:0] pc_d;
  logic            fault_q;
  logic            fault_d;
  logic [ILEN-1:0] word_idx;
  logic            in_range;
  logic            bad_pc;
  logic            fetch_try;
  logic            do_pop;
  logic            do_push;
  logic            q_full;
  logic            q_empty;
  logic [AW:0]     q_count;
  fetch_entry_t    q_wdata;
  fetch_entry_t    q_rdata;

  assign word_idx  = {2'b00, pc_q[ILEN-1:2]};
  assign imem_addr = word_idx;
  assign in_range  = word_idx < LIMIT;
  assign bad_pc    = pc_misaligned(pc_q) || !in_range;

  assign fetch_try = !fault_q && !redirect_valid;

  // A redirect squashes the head, so it must not count as consumed.
  assign do_pop  = out_ready && !q_empty && !redirect_valid;
  assign do_push = fetch_try && !bad_pc && (!q_full || do_pop);

  assign q_wdata = '{pc: pc_q, instr: imem_data};

  assign out_valid = (q_count != '0);
  assign out_instr = q_rdata.instr;
  assign out_pc    = q_rdata.pc;
  assign fault     = fault_q;

  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    unique case (1'b1)
      redirect_valid: begin
        pc_d    = redirect_pc;
        fault_d = 1'b0;
      end
      fetch_try && bad_pc: begin
        fault_d = 1'b1;
      end
      do_push: begin
        pc_d = pc_q + 32'd4;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (do_push),
    .pop_i   (do_pop),
    .flush_i (redirect_valid),
    .wdata_i (q_wdata),
    .rdata_o (q_rdata),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic,
// with two instances (full memory and a 4-word memory) against a model.
module tb_instruction_fetch;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        out_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  logic [31:0] mem [1024];
  logic [31:0] prog [6];

  logic [31:0] imem_addr [2];
  logic [31:0] imem_data [2];
  logic        out_valid [2];
  logic [31:0] out_instr [2];
  logic [31:0] out_pc [2];
  logic        fault [2];

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Behavioural model: a PC, a fault flag and an ordered list per instance.
  int          limit [2];
  logic [31:0] m_pc [2];
  bit          m_fault [2];
  logic [31:0] m_qpc [2][DEPTH];
  logic [31:0] m_qin [2][DEPTH];
  int          m_cnt [2];

  always #5 clk = ~clk;

  assign imem_data[0] = mem[imem_addr[0][9:0]];
  assign imem_data[1] = mem[imem_addr[1][9:0]];

  instruction_fetch #(
    .RESET_PC   (32'h0),
    .DEPTH      (DEPTH),
    .IMEM_WORDS (1024)
  ) dut_a (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr[0]),
    .imem_data      (imem_data[0]),
    .out_valid      (out_valid[0]),
    .out_ready      (out_ready),
    .out_instr      (out_instr[0]),
    .out_pc         (out_pc[0]),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault[0])
  );

  instruction_fetch #(
    .RESET_PC   (32'h0),
    .DEPTH      (DEPTH),
    .IMEM_WORDS (4)
  ) dut_b (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr[1]),
    .imem_data      (imem_data[1]),
    .out_valid      (out_valid[1]),
    .out_ready      (out_ready),
    .out_instr      (out_instr[1]),
    .out_pc         (out_pc[1]),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault[1])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i]    = 32'h0;
      m_fault[i] = 1'b0;
      m_cnt[i]   = 0;
    end
  endtask

  task automatic m_step();
    for (int i = 0; i < 2; i++) begin
      if (redirect_valid) begin
        m_cnt[i]   = 0;
        m_pc[i]    = redirect_pc;
        m_fault[i] = 1'b0;
      end else begin
        if (m_cnt[i] > 0 && out_ready) begin
          for (int k = 1; k < DEPTH; k++) begin
            m_qpc[i][k-1] = m_qpc[i][k];
            m_qin[i][k-1] = m_qin[i][k];
          end
          m_cnt[i]--;
        end
        if (!m_fault[i]) begin
          if (m_pc[i][1:0] != 2'b00 || (m_pc[i] >> 2) >= limit[i]) begin
            m_fault[i] = 1'b1;
          end else if (m_cnt[i] < DEPTH) begin
            m_qpc[i][m_cnt[i]] = m_pc[i];
            m_qin[i][m_cnt[i]] = mem[m_pc[i][11:2]];
            m_cnt[i]++;
            m_pc[i] = m_pc[i] + 32'd4;
          end
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) m_reset();
    else m_step();
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("valid[%0d]", i), 32'(out_valid[i]),
            32'(m_cnt[i] != 0));
        chk($sformatf("fault[%0d]", i), 32'(fault[i]), 32'(m_fault[i]));
        chk($sformatf("addr[%0d]", i), imem_addr[i], m_pc[i] >> 2);
        if (m_cnt[i] != 0) begin
          chk($sformatf("pc[%0d]", i), out_pc[i], m_qpc[i][0]);
          chk($sformatf("instr[%0d]", i), out_instr[i], m_qin[i][0]);
        end
      end
    end
  end

  initial begin
    limit[0] = 1024;
    limit[1] = 4;
    m_reset();
    prog[0] = 32'h00000093;
    prog[1] = 32'h00100113;
    prog[2] = 32'h002081b3;
    prog[3] = 32'h00310233;
    prog[4] = 32'h004182b3;
    prog[5] = 32'h0000006f;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int i = 0; i < 6; i++) mem[i] = prog[i];

    // Reset values
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid[0]), 32'h0);
    chk("rst_instr", out_instr[0], 32'h0);
    chk("rst_pc", out_pc[0], 32'h0);
    chk("rst_fault", 32'(fault[0]), 32'h0);
    chk("rst_addr", imem_addr[0], 32'h0);
    chk_on = 1'b1;
    #11 rst = 1'b1;

    // Streaming; instance B runs out of range after four words
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("s_pc", out_pc[0], 32'(k * 4));
      chk("s_instr", out_instr[0], prog[k]);
      chk("s_addr", imem_addr[0], 32'(k + 1));
      chk("oor_pc", out_pc[1], 32'(k * 4));
    end
    @(negedge clk);
    chk("oor_fault", 32'(fault[1]), 32'h1);
    chk("oor_addr", imem_addr[1], 32'h4);
    chk("oor_valid", 32'(out_valid[1]), 32'h0);

    // Backpressure from a fresh reset
    #2 rst = 1'b0;
    out_ready = 1'b0;
    #1 chk("bp_rst_valid", 32'(out_valid[0]), 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("bp_head_pc", out_pc[0], 32'h0);
      chk("bp_head_in", out_instr[0], prog[0]);
      chk("bp_addr", imem_addr[0], (k == 1) ? 32'h1 : 32'h2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("rel_pc4", out_pc[0], 32'h4);
    @(negedge clk);
    chk("rel_pc8", out_pc[0], 32'h8);

    // Redirect with a full queue
    redirect_valid = 1'b1;
    redirect_pc = 32'h14;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("rd_valid0", 32'(out_valid[0]), 32'h0);
    @(negedge clk);
    chk("rd_pc", out_pc[0], 32'h14);
    chk("rd_instr", out_instr[0], 32'h0000006f);

    // Misaligned redirect, then recovery
    redirect_valid = 1'b1;
    redirect_pc = 32'h6;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("mis_valid0", 32'(out_valid[0]), 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("mis_fault", 32'(fault[0]), 32'h1);
      chk("mis_valid", 32'(out_valid[0]), 32'h0);
      chk("mis_addr", imem_addr[0], 32'h1);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("rec_fault", 32'(fault[0]), 32'h0);
    @(negedge clk);
    chk("rec_pc", out_pc[0], 32'h0);
    chk("rec_instr", out_instr[0], prog[0]);

    // Asynchronous reset with the queue full
    out_ready = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mr_valid", 32'(out_valid[0]), 32'h0);
    chk("mr_pc", out_pc[0], 32'h0);
    chk("mr_instr", out_instr[0], 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mr_restart", out_pc[0], 32'h0);
    chk("mr_fault", 32'(fault[0]), 32'h0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 7))
        0: redirect_pc = ($urandom_range(0, 63) << 2) | 32'h2;
        1: redirect_pc = 32'hFFFF_FF00 | ($urandom_range(0, 63) << 2);
        2: redirect_pc = (1020 + $urandom_range(0, 3)) << 2;
        default: redirect_pc = $urandom_range(0, 15) << 2;
      endcase
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
      end
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Initiator side of the instruction-memory port. Owns the program counter, drives a word address into the combinational-read instruction memory, and captures each returned word together with its PC into a small instruction queue. The queue feeds decode over a valid/ready handshake. Control flow changes arrive as single-cycle redirects that flush the queue. Sits between `instruction_memory` and the decode stage of the core.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded at reset; must be word-aligned.
- `DEPTH`, 2: instruction queue entries; power of two, ≥2.
- `IMEM_WORDS`, 1024: number of valid memory words. A PC with `pc[31:2] >= IMEM_WORDS` is out of range.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `imem_addr` out 32: word index to instruction memory, `{2'b00, pc[31:2]}`.
- `imem_data` in 32: instruction word, valid in the same cycle as `imem_addr`.
- `out_valid` out 1: queue head holds an instruction.
- `out_ready` in 1: decode accepts the head.
- `out_instr` out 32: head instruction.
- `out_pc` out 32: byte PC of the head.
- `redirect_valid` in 1: one-cycle pulse requesting a fetch restart.
- `redirect_pc` in 32: byte target of the redirect.
- `fault` out 1: fetch halted on a misaligned or out-of-range PC.

## Operation
- Registers: `pc`, the queue (`DEPTH` × {pc, instr}), `count`, and `fault`.
- **Fetch attempt:** occurs each cycle when `!fault && !redirect_valid`.
  - If `pc[1:0] != 0` or `pc` is out of range: no push, and `fault <= 1`.
  - Otherwise, if there is space (`count < DEPTH`, or `count == DEPTH` with a pop in the same cycle): push {pc, imem_data} and `pc <= pc + 4`.
  - Otherwise: hold `pc`.
- **Pop:** when `out_valid && out_ready`. `out_valid = (count != 0)`. `out_instr` and `out_pc` come from the head and are don't-care when `out_valid` is 0.
- **Simultaneous push and pop:** `count` is unchanged. This holds in the full case too, so throughput stays one instruction per cycle with no bubble.
- **Redirect (highest priority):**
  - Queue flushed (`count <= 0`, pointers reset).
  - `pc <= redirect_pc`; `fault <= 0`.
  - No push that cycle. A concurrent pop is discarded: the flush wins, and decode must treat the head as squashed.
- **Fault state:**
  - `fault` stays set until a redirect or reset.
  - While faulted, entries already in the queue still drain normally.
  - `pc` holds at the faulting value.
  - A redirect to a bad target sets `fault` on the following cycle, when the fetch attempt is made.
- **PC wrap:** `pc + 4` wraps modulo 2^32. It is not reachable in practice because the range check faults first.

## Timing
- **Reset values** (asserted asynchronously):
  - `pc = RESET_PC`, `count = 0`, `fault = 0`.
  - `out_valid = 0`, `out_instr = 0`, `out_pc = 0`.
  - `imem_addr = RESET_PC >> 2`.
- **Reset mid-operation:** in-flight queue contents are lost immediately.
- **Fetch latency:** the first instruction appears (`out_valid = 1`) after the first rising edge following reset release.
- **Redirect latency:**
  - Redirect sampled at edge N.
  - `out_valid = 0` in the cycle after N.
  - Target instruction at the head after edge N+1.
- **Steady state:** one instruction per cycle with `out_ready` held high.
- **Combinational paths:** `imem_addr` depends only on the `pc` register. The only combinational path is `imem_data` → queue write data.
- **Backpressure:** `out_ready` deasserted never drops or duplicates an entry. `out_instr` and `out_pc` stay stable while `out_valid && !out_ready`, unless a redirect occurs.

## Structure
- **Package `fetch_pkg`:** `ILEN` = 32, the default `RESET_PC`, and the queue entry typedef {pc[31:0], instr[31:0]}.
- **Sub-module `fetch_queue`:** a synchronous FIFO with `DEPTH` entries. It provides push, pop, flush, full, empty and count, with pointer wrap at `DEPTH` and simultaneous push and pop allowed when full.
- **Top level:** holds the PC, fault logic and redirect priority.

## Test plan
1. **Reset and streaming.** Memory holds 00000093, 00100113, 002081b3, 00310233, 004182b3, 0000006f; `out_ready = 1`.
   - Required: `out_pc` sequence 0, 4, 8, 0xC in consecutive cycles.
   - Required: instructions 00000093, 00100113, 002081b3, 00310233.
   - Required: `imem_addr` sequence 0, 1, 2, 3, 4.
2. **Backpressure.** Hold `out_ready = 0` for 4 cycles, then release.
   - While held: queue fills after 2 edges; `pc` holds at 8; `imem_addr = 2`; head stays at pc 0 / 00000093.
   - After release: pc 0, 4, 8 delivered with no gap.
3. **Redirect with a full queue.** Pulse redirect to 0x14 while `out_ready = 1`.
   - Required: next cycle `out_valid = 0`.
   - Required: following cycle `out_pc = 0x14`, `out_instr = 0000006f`.
   - Required: no stale entry from 4 or 8 ever appears.
4. **Misaligned redirect.** Pulse redirect to 0x6.
   - Required: `fault = 1` after the next edge; `out_valid` stays 0; `imem_addr` stays 1.
   - Then redirect to 0x0: `fault` clears and pc 0 / 00000093 is delivered.
5. **Out of range.** `IMEM_WORDS = 4`, `out_ready = 1`.
   - Required: pcs 0, 4, 8, 0xC are delivered, then `fault = 1` with `pc = 0x10`, and nothing further is pushed.
6. **Reset mid-stream.** Assert `rst = 0` asynchronously with the queue full.
   - Required: `out_valid` drops before the next edge.
   - Required: after release, streaming restarts at `RESET_PC` with `fault = 0`.
